// File: rtl/i2c_arb_pkg.sv
// i2c_arb_pkg: shared types and widths for the I2C request arbiter.
//   state_t            - arbiter FSM state (2-bit)
//   DEV_W/REG_W/DAT_W  - device byte, register address and data widths
package i2c_arb_pkg;

  localparam int unsigned DEV_W = 8;
  localparam int unsigned REG_W = 16;
  localparam int unsigned DAT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

endpackage

// File: rtl/i2c_req_arbiter_if.sv
// i2c_req_arbiter_if: bundles the requester-side and I2C-master-side signals of the arbiter.
//   modport master - the arbiter's view: it drives acks, read data, status and the master
//                    request/address/data lines.
//   modport slave  - the environment's view: requesters plus the I2C master engine.
// Parameters NUM_REQ / IDX_W must match those of the arbiter instance.
interface i2c_req_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 3
);
  import i2c_arb_pkg::*;

  // Requester side
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_is_read;
  logic [NUM_REQ-1:0]       req_addr_2byte;
  logic [DEV_W*NUM_REQ-1:0] req_dev_addr;
  logic [REG_W*NUM_REQ-1:0] req_reg_addr;
  logic [DAT_W*NUM_REQ-1:0] req_wdata;
  logic [NUM_REQ-1:0]       req_ack;
  logic [DAT_W-1:0]         req_rdata;
  logic                     req_err;
  logic                     busy;
  logic [IDX_W-1:0]         grant_idx;

  // I2C master side
  logic                     i2c_read_req;
  logic                     i2c_write_req;
  logic                     i2c_read_req_ack;
  logic                     i2c_write_req_ack;
  logic                     i2c_addr_2byte;
  logic [DEV_W-1:0]         i2c_slave_dev_addr;
  logic [REG_W-1:0]         i2c_slave_reg_addr;
  logic [DAT_W-1:0]         i2c_write_data;
  logic [DAT_W-1:0]         i2c_read_data;
  logic                     i2c_error;

  modport master (
    input  req_valid, req_is_read, req_addr_2byte, req_dev_addr, req_reg_addr, req_wdata,
    output req_ack, req_rdata, req_err, busy, grant_idx,
    output i2c_read_req, i2c_write_req, i2c_addr_2byte, i2c_slave_dev_addr,
    output i2c_slave_reg_addr, i2c_write_data,
    input  i2c_read_req_ack, i2c_write_req_ack, i2c_read_data, i2c_error
  );

  modport slave (
    output req_valid, req_is_read, req_addr_2byte, req_dev_addr, req_reg_addr, req_wdata,
    input  req_ack, req_rdata, req_err, busy, grant_idx,
    input  i2c_read_req, i2c_write_req, i2c_addr_2byte, i2c_slave_dev_addr,
    input  i2c_slave_reg_addr, i2c_write_data,
    output i2c_read_req_ack, i2c_write_req_ack, i2c_read_data, i2c_error
  );

endinterface

// File: rtl/i2c_rr_pick.sv
// i2c_rr_pick: combinational round-robin picker.
//   req   in  NUM_REQ  request vector
//   ptr   in  IDX_W    highest-priority position (must be < NUM_REQ)
//   found out 1        any request set
//   idx   out IDX_W    first set position at or after ptr, wrapping modulo NUM_REQ
module i2c_rr_pick #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;

  // Rotate so that bit 0 of rot is the request at ptr.
  assign dbl = {req, req} >> ptr;
  assign rot = dbl[NUM_REQ-1:0];

  always_comb begin
    int pos;
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    // Descending scan: the lowest rotated offset is written last and wins.
    for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
      if (rot[k]) begin
        pos = int'(ptr) + k;
        if (pos >= int'(NUM_REQ)) pos = pos - int'(NUM_REQ);
        found = 1'b1;
        idx   = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter: shares one I2C master engine between NUM_REQ requesters.
// Round-robin grant, latches the winning request into the master-facing registers, runs the
// level-request / pulse-ack handshake and returns read data and NACK status with a one-cycle
// req_ack pulse to the granted requester.
//   clk, rst  - clock, asynchronous active-high reset
//   bus       - i2c_req_arbiter_if.master: requester fields/acks, busy, grant_idx, and the
//               master request, address, data and completion lines
module i2c_req_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IDX_W   = 3
) (
  input logic               clk,
  input logic               rst,
  i2c_req_arbiter_if.master bus
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic               is_read_q, is_read_d;
  logic               addr_2byte_q, addr_2byte_d;
  logic [DEV_W-1:0]   dev_q, dev_d;
  logic [REG_W-1:0]   reg_q, reg_d;
  logic [DAT_W-1:0]   wdata_q, wdata_d;
  logic               rd_req_q, rd_req_d;
  logic               wr_req_q, wr_req_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [DAT_W-1:0]   rdata_q, rdata_d;
  logic               err_q, err_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic               op_ack;

  i2c_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (bus.req_valid),
    .ptr   (rr_ptr_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Only the ack matching the latched operation completes the transfer.
  assign op_ack = is_read_q ? bus.i2c_read_req_ack : bus.i2c_write_req_ack;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    is_read_d    = is_read_q;
    addr_2byte_d = addr_2byte_q;
    dev_d        = dev_q;
    reg_d        = reg_q;
    wdata_d      = wdata_q;
    rd_req_d     = rd_req_q;
    wr_req_d     = wr_req_q;
    ack_d        = '0;
    rdata_d      = rdata_q;
    err_d        = err_q;

    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (pick_idx == IDX_W'(i)) begin
              is_read_d    = bus.req_is_read[i];
              addr_2byte_d = bus.req_addr_2byte[i];
              dev_d        = bus.req_dev_addr[DEV_W*i +: DEV_W];
              reg_d        = bus.req_reg_addr[REG_W*i +: REG_W];
              wdata_d      = bus.req_wdata[DAT_W*i +: DAT_W];
            end
          end
          grant_d  = pick_idx;
          rr_ptr_d = (int'(pick_idx) == int'(NUM_REQ) - 1) ? '0 : pick_idx + 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        rd_req_d = is_read_q;
        wr_req_d = ~is_read_q;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if (op_ack) begin
          rd_req_d = 1'b0;
          wr_req_d = 1'b0;
          rdata_d  = bus.i2c_read_data;
          err_d    = bus.i2c_error;
          for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant_q == IDX_W'(i)) ack_d[i] = 1'b1;
          end
          state_d = S_RELEASE;
        end
      end
      // Dead cycle: gives the requester one edge to drop req_valid.
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_ptr_q     <= '0;
      grant_q      <= '0;
      is_read_q    <= 1'b0;
      addr_2byte_q <= 1'b0;
      dev_q        <= '0;
      reg_q        <= '0;
      wdata_q      <= '0;
      rd_req_q     <= 1'b0;
      wr_req_q     <= 1'b0;
      ack_q        <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      is_read_q    <= is_read_d;
      addr_2byte_q <= addr_2byte_d;
      dev_q        <= dev_d;
      reg_q        <= reg_d;
      wdata_q      <= wdata_d;
      rd_req_q     <= rd_req_d;
      wr_req_q     <= wr_req_d;
      ack_q        <= ack_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  assign bus.req_ack            = ack_q;
  assign bus.req_rdata          = rdata_q;
  assign bus.req_err            = err_q;
  assign bus.busy               = (state_q != S_IDLE);
  assign bus.grant_idx          = grant_q;
  assign bus.i2c_read_req       = rd_req_q;
  assign bus.i2c_write_req      = wr_req_q;
  assign bus.i2c_addr_2byte     = addr_2byte_q;
  assign bus.i2c_slave_dev_addr = dev_q;
  assign bus.i2c_slave_reg_addr = reg_q;
  assign bus.i2c_write_data     = wdata_q;

endmodule
